therm_code_monitor: RTL and testbench

THERM_CODE_MONITOR -- requirements
Module: therm_code_monitor

---
 rtl/therm_mon_pkg.sv | 15 +
 rtl/therm_code_monitor_decode.sv | 28 ++
 rtl/therm_code_monitor.sv | 101 ++++++++++
 tb/tb_therm_code_monitor.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/therm_mon_pkg.sv
// Shared types and helpers for the thermometer-code monitor.
package therm_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } mon_state_t;

   // Bits needed to hold a level in 0..width inclusive.
   function automatic int lvl_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/therm_code_monitor_decode.sv
// Combinational thermometer-code decoder: validity, extremes and popcount level.
module therm_decode
   import therm_mon_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]           in_code,
   output logic                       therm_ok,
   output logic                       all_ones,
   output logic                       all_zeros,
   output logic [lvl_w(WIDTH)-1:0]    level
);

   localparam int LW = lvl_w(WIDTH);

   // A set bit sitting above a clear bit breaks the fill-from-bit-0 rule.
   assign therm_ok  = ~|(in_code[WIDTH-1:1] & ~in_code[WIDTH-2:0]);
   assign all_ones  = &in_code;
   assign all_zeros = ~|in_code;

   always_comb begin
      level = '0;
      for (int i = 0; i < WIDTH; i++) begin
         level = level + LW'(in_code[i]);
      end
   end

endmodule

// File: rtl/therm_code_monitor.sv
// Thermometer-code monitor: decodes each sample, tracks the last good level,
// counts bad samples and latches FAULT after FAULT_THR consecutive bad ones.
module therm_code_monitor
   import therm_mon_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CNT_W     = 8,
   parameter int FAULT_THR = 3,
   parameter int MAX_STEP  = WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_code,
   input  logic                       clr,
   output logic                       out_valid,
   output logic                       therm_ok,
   output logic                       all_ones,
   output logic                       all_zeros,
   output logic [lvl_w(WIDTH)-1:0]    level,
   output logic                       step_err,
   output logic [CNT_W-1:0]           err_cnt,
   output logic                       sticky_err,
   output logic                       fault
);

   localparam int LW = lvl_w(WIDTH);

   mon_state_t       state;
   logic [LW-1:0]    prev_level;
   logic [LW-1:0]    dec_level;
   logic [LW-1:0]    diff;
   logic             dec_ok, dec_ones, dec_zeros, dec_step, dec_bad;
   logic [CNT_W-1:0] consec, consec_nxt, err_nxt;

   therm_decode #(.WIDTH(WIDTH)) u_decode (
      .in_code   (in_code),
      .therm_ok  (dec_ok),
      .all_ones  (dec_ones),
      .all_zeros (dec_zeros),
      .level     (dec_level)
   );

   // No reference level exists in IDLE, so the step check is suppressed there.
   always_comb begin
      diff       = (dec_level >= prev_level) ? (dec_level - prev_level) : (prev_level - dec_level);
      dec_step   = dec_ok && (state != IDLE) && (int'(diff) > MAX_STEP);
      dec_bad    = !dec_ok || dec_step;
      consec_nxt = (&consec)  ? consec  : consec  + CNT_W'(1);
      err_nxt    = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
   end

   assign fault = (state == FAULT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         prev_level <= '0;
         consec     <= '0;
         out_valid  <= 1'b0;
         therm_ok   <= 1'b0;
         all_ones   <= 1'b0;
         all_zeros  <= 1'b0;
         level      <= '0;
         step_err   <= 1'b0;
         err_cnt    <= '0;
         sticky_err <= 1'b0;
      end else if (clr) begin
         state      <= IDLE;
         prev_level <= '0;
         consec     <= '0;
         out_valid  <= 1'b0;
         err_cnt    <= '0;
         sticky_err <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            therm_ok  <= dec_ok;
            all_ones  <= dec_ones;
            all_zeros <= dec_zeros;
            step_err  <= dec_step;
            level     <= dec_ok ? dec_level : prev_level;
            if (dec_bad) begin
               err_cnt    <= err_nxt;
               sticky_err <= 1'b1;
               consec     <= consec_nxt;
               if (state == TRACK && int'(consec_nxt) >= FAULT_THR) begin
                  state <= FAULT;
               end
            end else begin
               prev_level <= dec_level;
               consec     <= '0;
               if (state == IDLE) begin
                  state <= TRACK;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_therm_code_monitor.sv
// Directed self-checking bench for therm_code_monitor (WIDTH=16, CNT_W=2, FAULT_THR=3, MAX_STEP=4).
module tb_therm_code_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_code;
   logic        clr;
   logic        out_valid, therm_ok, all_ones, all_zeros, step_err, sticky_err, fault;
   logic [4:0]  level;
   logic [1:0]  err_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   therm_code_monitor #(
      .WIDTH(16), .CNT_W(2), .FAULT_THR(3), .MAX_STEP(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .clr(clr),
      .out_valid(out_valid), .therm_ok(therm_ok), .all_ones(all_ones), .all_zeros(all_zeros),
      .level(level), .step_err(step_err), .err_cnt(err_cnt), .sticky_err(sticky_err),
      .fault(fault)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] code);
      in_valid = 1'b1;
      in_code  = code;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   initial begin
      // Reset held for two edges with a bad sample presented; it must be ignored.
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_code = 16'h00F7;
      cyc(); cyc();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_therm_ok", therm_ok, 0);
      chk("rst_all_ones", all_ones, 0);
      chk("rst_all_zeros", all_zeros, 0);
      chk("rst_level", level, 0);
      chk("rst_step_err", step_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_sticky", sticky_err, 0);
      chk("rst_fault", fault, 0);

      // First cycle out of reset carries the first sample.
      rst_n = 1'b1;
      send(16'h00FF);
      chk("dec00FF_valid", out_valid, 1);
      chk("dec00FF_ok", therm_ok, 1);
      chk("dec00FF_level", level, 8);
      chk("dec00FF_step", step_err, 0);
      send(16'hFFFF);
      chk("decFFFF_ones", all_ones, 1);
      chk("decFFFF_level", level, 16);
      chk("decFFFF_step", step_err, 1);
      chk("decFFFF_errcnt", err_cnt, 1);
      send(16'h0000);
      chk("dec0000_zeros", all_zeros, 1);
      chk("dec0000_ones", all_ones, 0);
      chk("dec0000_level", level, 0);
      chk("dec0000_step", step_err, 1);
      cyc();
      chk("idle_valid", out_valid, 0);
      chk("idle_level_hold", level, 0);
      chk("idle_zeros_hold", all_zeros, 1);

      // Bad code: level holds the last good level (cleared to 0 by clr).
      do_clr();
      chk("clr_errcnt", err_cnt, 0);
      chk("clr_sticky", sticky_err, 0);
      send(16'h00F7);
      chk("bad_ok", therm_ok, 0);
      chk("bad_level", level, 0);
      chk("bad_errcnt", err_cnt, 1);
      chk("bad_sticky", sticky_err, 1);

      // Fault entry after three consecutive bad samples in TRACK.
      do_clr();
      send(16'h000F);
      chk("flt_good_level", level, 4);
      send(16'h00F7);
      chk("flt_bad1_fault", fault, 0);
      send(16'h0F0F);
      chk("flt_bad2_fault", fault, 0);
      chk("flt_bad2_errcnt", err_cnt, 2);
      send(16'h8000);
      chk("flt_bad3_errcnt", err_cnt, 3);
      cyc();
      chk("flt_fault_set", fault, 1);
      // clr with a sample in flight: clr wins and the sample is dropped.
      clr = 1'b1; in_valid = 1'b1; in_code = 16'h000F;
      cyc();
      clr = 1'b0; in_valid = 1'b0;
      chk("flt_clr_fault", fault, 0);
      chk("flt_clr_errcnt", err_cnt, 0);
      chk("flt_clr_valid", out_valid, 0);
      // Back in IDLE: a big jump is not a step error.
      send(16'h0FFF);
      chk("flt_idle_step", step_err, 0);
      chk("flt_idle_level", level, 12);

      // Step checks always use the last good level (4 here).
      do_clr();
      send(16'h000F);
      chk("stp_000F_step", step_err, 0);
      send(16'h0FFF);
      chk("stp_0FFF_step", step_err, 1);
      chk("stp_0FFF_level", level, 12);
      send(16'h01FF);
      chk("stp_01FF_step", step_err, 1);
      // |8-4| == MAX_STEP is still legal.
      send(16'h00FF);
      chk("stp_00FF_step", step_err, 0);
      chk("stp_00FF_level", level, 8);
      chk("stp_fault", fault, 0);

      // Error counter saturation at 3.
      do_clr();
      send(16'h00F7); chk("sat_1", err_cnt, 1);
      send(16'h00F7); chk("sat_2", err_cnt, 2);
      send(16'h00F7); chk("sat_3", err_cnt, 3);
      send(16'h00F7); chk("sat_4", err_cnt, 3);
      send(16'h00F7); chk("sat_5", err_cnt, 3);

      // Reset mid-operation clears everything even with a sample presented.
      rst_n = 1'b0; in_valid = 1'b1; in_code = 16'h00FF;
      cyc();
      chk("midrst_errcnt", err_cnt, 0);
      chk("midrst_sticky", sticky_err, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_level", level, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
